// File: rtl/mult_seq.sv
// Sequential signed multiplier: radix-2 shift-add on operand magnitudes,
// followed by a sign-fix cycle that also flags truncation overflow.
module mult_seq #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] dataa,
  input  logic [DATA_WIDTH-1:0] datab,
  input  logic                  invalid_in,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  invalid_out
);

  localparam int unsigned W  = DATA_WIDTH;
  localparam int unsigned PW = 2 * DATA_WIDTH;
  localparam int unsigned CW = $clog2(DATA_WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t          state_q, state_d;
  logic            busy_d, done_d;
  logic            load_c, step_c, fix_c;
  logic [CW-1:0]   cnt_q;
  logic [PW-1:0]   acc_q;
  logic [PW-1:0]   mcand_q;
  logic [W-1:0]    mplier_q;
  logic            neg_q;
  logic            inv_q;
  logic [W-1:0]    mag_a_c, mag_b_c;
  logic [PW-1:0]   prod_c;
  logic [W:0]      prod_hi_c;
  logic            ovf_c;

  // Magnitudes are unsigned, so the most negative value maps to 2^(W-1) intact
  assign mag_a_c = dataa[W-1] ? (~dataa + W'(1)) : dataa;
  assign mag_b_c = datab[W-1] ? (~datab + W'(1)) : datab;

  assign prod_c    = neg_q ? (~acc_q + PW'(1)) : acc_q;
  assign prod_hi_c = prod_c[PW-1:W-1];
  assign ovf_c     = !((&prod_hi_c) || (~|prod_hi_c));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state and control decode
  always_comb begin
    state_d = state_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    load_c  = 1'b0;
    step_c  = 1'b0;
    fix_c   = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          load_c  = 1'b1;
          busy_d  = 1'b1;
          state_d = CALC;
        end else begin
          state_d = IDLE;
        end
      end
      CALC: begin
        step_c = 1'b1;
        busy_d = 1'b1;
        if (cnt_q == CW'(1)) state_d = FIX;
      end
      FIX: begin
        fix_c   = 1'b1;
        done_d  = 1'b1;
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy        <= 1'b0;
      done        <= 1'b0;
      result      <= '0;
      invalid_out <= 1'b0;
      cnt_q       <= '0;
      acc_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      neg_q       <= 1'b0;
      inv_q       <= 1'b0;
    end else begin
      busy <= busy_d;
      done <= done_d;
      if (load_c) begin
        cnt_q    <= CW'(W);
        acc_q    <= '0;
        mcand_q  <= {W'(0), mag_a_c};
        mplier_q <= mag_b_c;
        neg_q    <= dataa[W-1] ^ datab[W-1];
        inv_q    <= invalid_in;
      end
      if (step_c) begin
        if (mplier_q[0]) acc_q <= acc_q + mcand_q;
        mcand_q  <= mcand_q << 1;
        mplier_q <= mplier_q >> 1;
        cnt_q    <= cnt_q - CW'(1);
      end
      if (fix_c) begin
        result      <= prod_c[W-1:0];
        invalid_out <= inv_q | ovf_c;
      end
    end
  end

endmodule

// File: tb/tb_mult_seq.sv
// Directed self-checking bench for mult_seq at DATA_WIDTH=8.
module tb_mult_seq;

  logic       clk, rst, start, invalid_in;
  logic [7:0] dataa, datab;
  logic       busy, done, invalid_out;
  logic [7:0] result;

  int         total, bad;
  int         lat, bcnt;
  logic [7:0] r;
  logic       iv;
  bit         st, tmo;

  mult_seq #(.DATA_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .dataa(dataa), .datab(datab),
    .invalid_in(invalid_in), .busy(busy), .done(done), .result(result),
    .invalid_out(invalid_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Runs one operation from a negedge; lat counts cycles from the start cycle to the done cycle.
  task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic inv_in,
                       output int l, output int bc, output logic [7:0] res,
                       output logic inv, output bit stable, output bit to);
    logic [7:0] prev_res;
    logic       prev_inv;
    prev_res = result;
    prev_inv = invalid_out;
    dataa = a; datab = b; invalid_in = inv_in; start = 1'b1;
    l = 0; bc = 0; stable = 1'b1; to = 1'b1;
    @(posedge clk);
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (k == 0) start = 1'b0;
      if (busy) bc++;
      if (done) begin
        l = k + 1;
        to = 1'b0;
        break;
      end
      if (result !== prev_res || invalid_out !== prev_inv) stable = 1'b0;
    end
    res = result;
    inv = invalid_out;
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b0; dataa = '0; datab = '0; invalid_in = 1'b0;
    #2 rst = 1'b1;
    #1;
    total++;
    if ({busy, done, result, invalid_out} !== 11'd0) begin
      bad++;
      $display("FAIL reset_async: got busy=%b done=%b result=%h inv=%b want all 0",
               busy, done, result, invalid_out);
    end
    @(negedge clk);
    @(negedge clk);
    total++;
    if ({busy, done, result, invalid_out} !== 11'd0) begin
      bad++;
      $display("FAIL reset_held: got busy=%b done=%b result=%h inv=%b want all 0",
               busy, done, result, invalid_out);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    do_op(8'd3, 8'd5, 1'b0, lat, bcnt, r, iv, st, tmo);
    total++; if (tmo !== 1'b0) begin bad++; $display("FAIL basic_timeout: got no done want done"); end
    total++; if (lat !== 10) begin bad++; $display("FAIL basic_latency: got %0d want 10", lat); end
    total++; if (bcnt !== 9) begin bad++; $display("FAIL basic_busy_cycles: got %0d want 9", bcnt); end
    total++; if (r !== 8'h0F) begin bad++; $display("FAIL basic_result: got %h want 0f", r); end
    total++; if (iv !== 1'b0) begin bad++; $display("FAIL basic_invalid: got %b want 0", iv); end
    total++; if (st !== 1'b1) begin bad++; $display("FAIL basic_hold_in_calc: got changed want held"); end
    @(negedge clk);
    total++; if (done !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL basic_after_done: got done=%b busy=%b want 0 0", done, busy); end
  endtask

  task automatic test_signed();
    do_op(8'hFC, 8'd6, 1'b0, lat, bcnt, r, iv, st, tmo);
    total++; if (r !== 8'hE8 || iv !== 1'b0) begin bad++; $display("FAIL signed_m4x6: got %h/%b want e8/0", r, iv); end
    do_op(8'h80, 8'd1, 1'b0, lat, bcnt, r, iv, st, tmo);
    total++; if (r !== 8'h80 || iv !== 1'b0) begin bad++; $display("FAIL signed_m128x1: got %h/%b want 80/0", r, iv); end
    do_op(8'h80, 8'hFF, 1'b0, lat, bcnt, r, iv, st, tmo);
    total++; if (r !== 8'h80 || iv !== 1'b1) begin bad++; $display("FAIL signed_m128xm1: got %h/%b want 80/1", r, iv); end
    total++; if (lat !== 10) begin bad++; $display("FAIL signed_latency: got %0d want 10", lat); end
  endtask

  task automatic test_invalid();
    do_op(8'd16, 8'd16, 1'b0, lat, bcnt, r, iv, st, tmo);
    total++; if (r !== 8'h00 || iv !== 1'b1) begin bad++; $display("FAIL invalid_overflow: got %h/%b want 00/1", r, iv); end
    do_op(8'd2, 8'd2, 1'b1, lat, bcnt, r, iv, st, tmo);
    total++; if (r !== 8'h04 || iv !== 1'b1) begin bad++; $display("FAIL invalid_passthru: got %h/%b want 04/1", r, iv); end
    total++; if (st !== 1'b1) begin bad++; $display("FAIL invalid_hold_in_calc: got changed want held"); end
  endtask

  task automatic test_zero();
    do_op(8'd0, 8'd93, 1'b0, lat, bcnt, r, iv, st, tmo);
    total++; if (lat !== 10) begin bad++; $display("FAIL zero_latency: got %0d want 10", lat); end
    total++; if (r !== 8'h00 || iv !== 1'b0) begin bad++; $display("FAIL zero_a: got %h/%b want 00/0", r, iv); end
    do_op(8'hF9, 8'd0, 1'b1, lat, bcnt, r, iv, st, tmo);
    total++; if (r !== 8'h00 || iv !== 1'b1) begin bad++; $display("FAIL zero_b_inv: got %h/%b want 00/1", r, iv); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [7:0] opa [3];
    logic [7:0] opb [3];
    logic [7:0] expr [3];
    logic       expi [3];
    int         idx, last;
    logic       prev_done;
    opa = '{8'd3, 8'hFC, 8'h80};
    opb = '{8'd5, 8'd6, 8'hFF};
    expr = '{8'h0F, 8'hE8, 8'h80};
    expi = '{1'b0, 1'b0, 1'b1};
    dataa = opa[0]; datab = opb[0]; invalid_in = 1'b0; start = 1'b1;
    @(posedge clk);
    idx = 0; last = 0; prev_done = 1'b0;
    for (int c = 0; c < 60 && idx < 3; c++) begin
      @(negedge clk);
      if (done) begin
        total++; if (result !== expr[idx]) begin bad++; $display("FAIL b2b_result%0d: got %h want %h", idx, result, expr[idx]); end
        total++; if (invalid_out !== expi[idx]) begin bad++; $display("FAIL b2b_invalid%0d: got %b want %b", idx, invalid_out, expi[idx]); end
        if (idx > 0) begin
          total++; if (c - last !== 10) begin bad++; $display("FAIL b2b_interval%0d: got %0d want 10", idx, c - last); end
        end
        total++; if (prev_done !== 1'b0) begin bad++; $display("FAIL b2b_pulse_width%0d: got 2+ cycles want 1", idx); end
        last = c;
        idx++;
        if (idx < 3) begin dataa = opa[idx]; datab = opb[idx]; end
        else start = 1'b0;
      end else begin
        dataa = 8'($urandom);
        datab = 8'($urandom);
      end
      prev_done = done;
    end
    total++; if (idx !== 3) begin bad++; $display("FAIL b2b_timeout: got %0d ops want 3", idx); end
    @(negedge clk);
    total++; if (done !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL b2b_idle: got done=%b busy=%b want 0 0", done, busy); end
  endtask

  task automatic test_abort();
    int seen;
    dataa = 8'd100; datab = 8'd3; invalid_in = 1'b1; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    total++;
    if ({busy, done, result, invalid_out} !== 11'd0) begin
      bad++;
      $display("FAIL abort_async: got busy=%b done=%b result=%h inv=%b want all 0",
               busy, done, result, invalid_out);
    end
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (done || busy || result !== 8'h00) seen++;
    end
    total++; if (seen !== 0) begin bad++; $display("FAIL abort_no_done: got %0d active cycles want 0", seen); end
    @(posedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    do_op(8'd7, 8'd7, 1'b0, lat, bcnt, r, iv, st, tmo);
    total++; if (lat !== 10) begin bad++; $display("FAIL post_reset_latency: got %0d want 10", lat); end
    total++; if (r !== 8'h31 || iv !== 1'b0) begin bad++; $display("FAIL post_reset_result: got %h/%b want 31/0", r, iv); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    @(negedge clk);
    test_basic();
    test_signed();
    test_invalid();
    test_zero();
    test_back_to_back();
    test_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
